// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard-sequencer state encoding, register constants
// and the load-use decode used by the hazard and forwarding blocks.
package pipeline_pkg;

    localparam logic [1:0] START    = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;

    localparam logic [4:0] REG_X0 = 5'd0;

    // x0 never carries a real dependency, so a load to x0 cannot cause a load-use stall.
    function automatic logic load_use_hit(input logic       memread,
                                          input logic [4:0] rd,
                                          input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return memread && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes, data-memory wait freeze with timeout, post-reset clear and statistics.
module hazard_sequencer #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    import pipeline_pkg::*;

    logic [1:0] state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_error_q, mem_error_d;

    logic in_wait;
    logic timeout;
    logic mem_hold;
    logic load_use;
    logic flush_event;
    logic stall_event;
    logic in_start;

    assign in_start = (state_q == START);
    assign in_wait  = (state_q == MEM_WAIT);
    assign load_use = load_use_hit(id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2);
    assign timeout  = in_wait && !mem_ready && (wait_q >= 8'(MEM_TIMEOUT));
    // Once waiting, only ready or the timeout releases the freeze.
    assign mem_hold = in_wait ? (!mem_ready && !timeout) : (mem_req && !mem_ready);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        state_d      = state_q;
        wait_d       = wait_q;
        mem_error_d  = mem_error_q;
        flush_event  = 1'b0;

        if (in_start) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            state_d      = RUN;
            wait_d       = '0;
        end else if (mem_hold) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
            state_d      = MEM_WAIT;
            wait_d       = in_wait ? (wait_q + 8'd1) : 8'd1;
        end else begin
            state_d = RUN;
            wait_d  = '0;
            // Abandoned access: the dropped load must not reach write-back.
            if (timeout) begin
                mem_wb_flush = 1'b1;
                mem_error_d  = 1'b1;
            end
            if (branch_taken && !mem_req) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                flush_event  = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign stall_event = !in_start && !pc_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= START;
            wait_q      <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign mem_error = mem_error_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (reset),
        .clear (in_start),
        .inc   (stall_event),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (reset),
        .clear (in_start),
        .inc   (flush_event),
        .count (flush_count)
    );

    // Branch and memory request both come from the single MEM-stage instruction.
    a_branch_mem_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(branch_taken && mem_req))
        else $error("branch_taken asserted together with mem_req");

endmodule
